// File: rtl/serial_add_ctrl.sv
// Nibble-serial 16-bit adder/subtractor: one 4-bit slice reused over four RUN cycles,
// LSB nibble first, then a single-cycle DONE that pulses done.
module serial_add_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sub,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [3:0]  a_nib, b_nib, s_nib;
  logic        c_out, c_msb;

  // The single shared add slice; c_msb recovers the carry into the nibble's top bit.
  always_comb begin
    a_nib          = a_q[{idx_q, 2'b00} +: 4];
    b_nib          = b_q[{idx_q, 2'b00} +: 4];
    {c_out, s_nib} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    c_msb          = a_nib[3] ^ b_nib[3] ^ s_nib[3];
  end

  // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          idx_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = s_nib;
        carry_d = c_out;
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          cout_d  = c_out;
          ovf_d   = c_msb ^ c_out;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: operand registers are left unreset; they are always loaded before RUN reads them.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: arithmetic vectors, held start with changing
// operands, and synchronous reset in the middle of an operation.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, sub;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  int vectors = 0;
  int miscompares = 0;

  serial_add_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
      end
  endtask

  // One operation: start for a single edge, then done must appear exactly 4 edges later.
  task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic op_sub, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    a = op_a; b = op_b; sub = op_sub; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~op_a; b = ~op_b; sub = ~op_sub;
    check({tag, " busy after start"}, {15'd0, busy}, 16'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check({tag, " done early"}, {15'd0, done}, 16'd0);
    end
    tick();
    check({tag, " done"}, {15'd0, done}, 16'd1);
    check({tag, " sum"},  sum,  exp_sum);
    check({tag, " cout"}, {15'd0, cout}, {15'd0, exp_cout});
    check({tag, " ovf"},  {15'd0, ovf},  {15'd0, exp_ovf});
    tick();
    check({tag, " done pulse width"}, {15'd0, done}, 16'd0);
    check({tag, " idle again"}, {15'd0, busy}, 16'd0);
    tick();
    check({tag, " sum held"}, sum, exp_sum);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 16'h0000; b = 16'h0000;
    tick();
    tick();
    check("reset busy", {15'd0, busy}, 16'd0);
    check("reset done", {15'd0, done}, 16'd0);
    check("reset sum",  sum, 16'h0000);
    check("reset cout", {15'd0, cout}, 16'd0);
    check("reset ovf",  {15'd0, ovf},  16'd0);
    rst_n = 1'b1;
    tick();

    run_op("add_5555",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Reset asserted during the second RUN cycle aborts the operation.
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort in run", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", {15'd0, busy}, 16'd0);
    check("abort done", {15'd0, done}, 16'd0);
    check("abort sum",  sum, 16'h0000);
    check("abort cout", {15'd0, cout}, 16'd0);
    check("abort ovf",  {15'd0, ovf},  16'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no done after abort", {15'd0, done}, 16'd0);
    end

    // start held high throughout; operands change mid-operation.
    a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
    tick();
    check("held first accept", {15'd0, busy}, 16'd1);
    a = 16'h00FF; b = 16'h0100;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("held done early", {15'd0, done}, 16'd0);
    end
    tick();
    check("held first done", {15'd0, done}, 16'd1);
    check("held first sum", sum, 16'h0002);
    a = 16'h0003; b = 16'h0004;
    tick();
    check("held idle gap", {15'd0, busy}, 16'd0);
    check("held gap no done", {15'd0, done}, 16'd0);
    tick();
    check("held second accept at 6", {15'd0, busy}, 16'd1);
    start = 1'b0;
    a = 16'hAAAA; b = 16'h5555;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("held second done early", {15'd0, done}, 16'd0);
    end
    tick();
    check("held second done", {15'd0, done}, 16'd1);
    check("held second sum", sum, 16'h0007);
    tick();
    check("held final idle", {15'd0, busy}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
